// File: rtl/osc_pkg.sv
// osc_pkg: debounce state encoding and default timing constants shared by the oscillator request path
package osc_pkg;
  localparam logic [1:0] REL       = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_PULSE_LEN   = 1;
  localparam int DEF_AUTO_PERIOD = 8;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus press/release debounce FSM
module btn_debounce
  import osc_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt,
  output logic btn_state
);
  localparam logic [7:0] DEB = 8'(DEB_CYCLES);
  logic       s1;
  logic       btn_s;
  logic [1:0] st;
  logic [7:0] cnt;
  // press_evt is combinational so the request lands on the same edge that enters HELD
  always_comb begin
    press_evt = (st == PRESS_CHK) && btn_s && (cnt == DEB);
    btn_state = (st == HELD) || (st == REL_CHK);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
      st    <= REL;
      cnt   <= 8'd0;
    end else begin
      s1    <= btn_raw;
      btn_s <= s1;
      case (st)
        REL:       if (btn_s) begin st <= PRESS_CHK; cnt <= 8'd1; end
        PRESS_CHK: if (!btn_s) begin st <= REL; cnt <= 8'd0; end
                   else if (cnt == DEB) st <= HELD;
                   else cnt <= cnt + 8'd1;
        HELD:      if (!btn_s) begin st <= REL_CHK; cnt <= 8'd1; end
        REL_CHK:   if (btn_s) st <= HELD;
                   else if (cnt == DEB) begin st <= REL; cnt <= 8'd0; end
                   else cnt <= cnt + 8'd1;
        default:   st <= REL;
      endcase
    end
  end
endmodule

// File: rtl/sw_req_gen.sv
// sw_req_gen: merges debounced button presses and auto-timer ticks into registered sw_a request pulses
module sw_req_gen
  import osc_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             auto_en,
  output logic             sw_a,
  output logic             btn_state,
  output logic             busy,
  output logic [CNT_W-1:0] sw_count
);
  localparam logic [15:0] AP_LAST = 16'(AUTO_PERIOD - 1);
  localparam logic [7:0]  PL      = 8'(PULSE_LEN);
  logic        press_evt;
  logic        auto_evt;
  logic        req;
  logic [15:0] acnt;
  logic [7:0]  pcnt;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .press_evt(press_evt),
    .btn_state(btn_state)
  );
  always_comb begin
    auto_evt = auto_en && (acnt == AP_LAST);
    req      = press_evt | auto_evt;
    busy     = sw_a;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acnt <= 16'd0;
    else acnt <= !auto_en ? 16'd0 : auto_evt ? 16'd0 : acnt + 16'd1;
  end
  // a request during an active pulse reloads pcnt, stretching sw_a
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_a     <= 1'b0;
      pcnt     <= 8'd0;
      sw_count <= '0;
    end else if (req) begin
      sw_a     <= 1'b1;
      pcnt     <= PL;
      sw_count <= sw_count + 1'b1;
    end else if (pcnt != 8'd0) begin
      sw_a <= (pcnt != 8'd1);
      pcnt <= pcnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_sw_req_gen.sv
// tb_sw_req_gen: random and directed stimulus on two parameterisations against a run-length reference model
module tb_sw_req_gen;
  logic clk = 1'b0;
  logic rst, btn_raw, auto_en;
  logic sw_a0, bs0, busy0, sw_a1, bs1, busy1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  sw_req_gen dut0 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .auto_en(auto_en),
    .sw_a(sw_a0), .btn_state(bs0), .busy(busy0), .sw_count(cnt0)
  );
  sw_req_gen #(.DEB_CYCLES(3), .PULSE_LEN(3), .AUTO_PERIOD(5), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .auto_en(auto_en),
    .sw_a(sw_a1), .btn_state(bs1), .busy(busy1), .sw_count(cnt1)
  );

  int deb_p[2] = '{4, 3};
  int pl_p[2]  = '{1, 3};
  int ap_p[2]  = '{8, 5};
  int cw_p[2]  = '{8, 2};
  bit raw_q[$];
  bit level[2];
  int run[2], arun[2], age[2], reqs[2];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < 2; i++) begin
      level[i] = 0; run[i] = 0; arun[i] = 0; age[i] = 1000; reqs[i] = 0;
    end
  endtask

  // level flips once DEB+1 consecutive opposite synchronized samples are seen
  task automatic model_edge();
    bit bs, press, aev;
    raw_q.push_back(btn_raw);
    bs = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 1'b0;
    if (raw_q.size() > 8) void'(raw_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      press = 0;
      if (bs != level[i]) begin
        run[i]++;
        if (run[i] == deb_p[i] + 1) begin
          level[i] = bs; run[i] = 0; press = bs;
        end
      end else run[i] = 0;
      aev = 0;
      if (auto_en) begin
        arun[i]++;
        aev = (arun[i] % ap_p[i]) == 0;
      end else arun[i] = 0;
      if (press || aev) begin
        age[i] = 0; reqs[i]++;
      end else if (age[i] < 1000) age[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("d0_sw_a", sw_a0, age[0] < pl_p[0]);
    chk("d0_busy", busy0, age[0] < pl_p[0]);
    chk("d0_btn_state", bs0, level[0]);
    chk("d0_sw_count", cnt0, reqs[0] % (1 << cw_p[0]));
    chk("d1_sw_a", sw_a1, age[1] < pl_p[1]);
    chk("d1_busy", busy1, age[1] < pl_p[1]);
    chk("d1_btn_state", bs1, level[1]);
    chk("d1_sw_count", cnt1, reqs[1] % (1 << cw_p[1]));
  endtask

  initial begin
    int rise, c0, n;
    int rises[$];
    rst = 1'b1; btn_raw = 1'b0; auto_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sw_a", sw_a0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_btn_state", bs0, 0);
    rst = 1'b0;
    model_reset();
    // clean press held long: one pulse at edge 6 only
    btn_raw = 1'b1;
    rise = -1;
    for (int e = 0; e < 60; e++) begin
      step();
      if (sw_a0 && rise < 0) rise = e;
    end
    chk("press_rise_edge", rise, 6);
    chk("press_count", cnt0, 1);
    btn_raw = 1'b0;
    repeat (20) step();
    // bounce then stable high: exactly one more request
    c0 = cnt0;
    btn_raw = 1'b1; repeat (3) step();
    btn_raw = 1'b0; repeat (2) step();
    btn_raw = 1'b1; repeat (40) step();
    chk("bounce_count_delta", int'(cnt0) - c0, 1);
    btn_raw = 1'b0;
    repeat (20) step();
    // auto mode: rises at edges 7, 15, 23 for the default period
    c0 = cnt0;
    auto_en = 1'b1;
    for (int e = 0; e < 24; e++) begin
      step();
      if (sw_a0) rises.push_back(e);
    end
    chk("auto_pulses", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("auto_edge0", rises[0], 7);
      chk("auto_edge1", rises[1], 15);
      chk("auto_edge2", rises[2], 23);
    end
    chk("auto_count_delta", int'(cnt0) - c0, 3);
    auto_en = 1'b0;
    repeat (20) step();
    // random button bounces and auto toggling
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(39) == 0) auto_en = ~auto_en;
      step();
    end
    // reset mid-pulse on the 3-cycle instance
    btn_raw = 1'b0; auto_en = 1'b1;
    n = 0;
    while (!(age[1] == 1) && n < 50) begin
      step();
      n++;
    end
    chk("midpulse_reached", n < 50, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sw_a", sw_a1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_count", cnt1, 0);
    chk("async_rst_count0", cnt0, 0);
    auto_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    auto_en = 1'b1;
    repeat (40) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
